mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the MAR/MDR datapath. Accepts Read/Write requests
//  (address from MAR, write data from MDR output Q), performs the access after a
//  fixed wait-state delay and returns read data on MDataIn, which feeds the MDR
//  input mux. Completion uses a 4-phase req/done handshake.
// PARAMETERS
//  DATA_W   32   data word width
//  ADDR_W   9    address width
//  DEPTH    512  words implemented, DEPTH <= 2**ADDR_W
//  LATENCY  2    wait cycles from request accept to access, legal range 1..15
// PORTS
//  clk        in   1       rising-edge clock
//  Clear      in   1       synchronous active-high reset
//  Addr       in   ADDR_W  word address (MAR output)
//  WrData     in   DATA_W  write data (MDR Q)
//  Read       in   1       read request; hold high until MemDone seen
//  Write      in   1       write request; hold high until MemDone seen
//  MDataIn    out  DATA_W  read data to MDR mux; holds last read value
//  MemBusy    out  1       high in WAIT state
//  MemDone    out  1       high in DONE state
//  MemErr     out  1       out-of-range flag; valid with MemDone
// BEHAVIOUR
//  - Reset (Clear=1 at an edge): state=IDLE, MDataIn=0, MemBusy=0, MemDone=0,
//    MemErr=0, counter=0. Memory array is not cleared. Clear beats all inputs.
//  - FSM states: IDLE, WAIT, DONE. Outputs are registered.
//  - IDLE: if Read|Write at edge N, latch Addr, WrData and op, load cnt=LATENCY-1,
//    go to WAIT. Read=Write=1 is a read; Write is ignored.
//  - WAIT: at each edge, if cnt==0, do the access and go to DONE; else cnt--.
//    The access happens at edge N+LATENCY. MemDone is high after that edge.
//  - Access:
//    - read: MDataIn <= mem[addr].
//    - write: mem[addr] <= wdata. MDataIn is unchanged.
//    - Only latched values are used. Input changes during WAIT are ignored.
//  - Out of range (addr >= DEPTH):
//    - read returns 0 on MDataIn.
//    - write is dropped and memory is unchanged.
//  - DONE: MemDone stays high while Read|Write is high. When both are low at an
//    edge, go to IDLE. A new request can be accepted one cycle later, so there
//    is no back-to-back accept from DONE.
//  - A request dropped during WAIT does not abort the access. DONE is entered
//    and exits on the next edge if the request is still low.
//  - Clear during WAIT aborts the access: no write commit, no MDataIn update.
//  - Minimum round trip: LATENCY+2 cycles from request high to IDLE.
// CONFIGURATION
//  MEM_BOUNDS_CHECK_EN defined:
//    - MemErr=1 in DONE when the latched addr >= DEPTH; otherwise 0.
//    - MemErr clears on leaving DONE.
//  MEM_BOUNDS_CHECK_EN undefined:
//    - MemErr tied to 0.
//    - Out-of-range accesses behave as above (read 0, write dropped), but no flag.
// TESTING
//  1. Clear=1 for 2 cycles with Read=1 -> MDataIn=0, MemBusy=0, MemDone=0,
//     state stays IDLE.
//  2. Write Addr=0x010, WrData=0xDEADBEEF (LATENCY=2) -> MemBusy high 2 cycles,
//     then MemDone high; MDataIn unchanged; drop Write -> MemDone low next cycle.
//  3. Read Addr=0x010 after test 2 -> MDataIn=0xDEADBEEF exactly when MemDone
//     rises (2 edges after accept); value holds after Read drops.
//  4. Read=Write=1, Addr=0x010, WrData=0x0 -> read performed; MDataIn=0xDEADBEEF;
//     a later read confirms mem[0x010] is still 0xDEADBEEF.
//  5. Write 0x12345678 to Addr=0x020, pulse Clear during WAIT -> read of 0x020
//     returns its previous value, not 0x12345678.
//  6. DEPTH=256, Read Addr=0x1FF with MEM_BOUNDS_CHECK_EN -> MDataIn=0, MemErr=1
//     with MemDone. Same test without the macro -> MemErr=0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR datapath: fixed wait-state access with a 4-phase req/done handshake.
// Define MEM_BOUNDS_CHECK_EN to raise MemErr alongside MemDone for out-of-range accesses.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDataIn,
  output logic              MemBusy,
  output logic              MemDone,
  output logic              MemErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                is_rd_r;
  logic                latch_s;
  logic                access_s;
  logic                in_range_s;
  logic [DATA_W-1:0]   mdata_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  assign in_range_s = ({1'b0, addr_r} < DEPTH_L);

  // Next-state logic: request accept, wait-state countdown, done handshake.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (Read || Write) begin
          state_nxt_s = S_WAIT;
          cnt_nxt_s   = LAT_LOAD;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = S_DONE;
          access_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      S_DONE: begin
        if (!(Read || Write)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, request latch and registered status/read-data outputs.
  always_ff @(posedge clk) begin
    if (Clear) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      is_rd_r <= 1'b0;
      mdata_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        addr_r  <= Addr;
        wdata_r <= WrData;
        // a simultaneous Read and Write is treated as a read
        is_rd_r <= Read;
      end
      if (access_s && is_rd_r) begin
        mdata_r <= in_range_s ? mem_r[addr_r[IDX_W-1:0]] : '0;
      end
      busy_r <= (state_nxt_s == S_WAIT);
      done_r <= (state_nxt_s == S_DONE);
`ifdef MEM_BOUNDS_CHECK_EN
      err_r  <= (state_nxt_s == S_DONE) && !in_range_s;
`else
      err_r  <= 1'b0;
`endif
    end
  end

  // Storage array; not cleared, and a Clear on the access edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!Clear && access_s && !is_rd_r && in_range_s) begin
      mem_r[addr_r[IDX_W-1:0]] <= wdata_r;
    end
  end

  assign MDataIn = mdata_r;
  assign MemBusy = busy_r;
  assign MemDone = done_r;
  assign MemErr  = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=256, LATENCY=2); expected MemErr follows MEM_BOUNDS_CHECK_EN.
module tb_mem_responder;

  localparam int LAT = 2;
  localparam int DEP = 256;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        Clear;
  logic [8:0]  Addr;
  logic [31:0] WrData;
  logic        Read;
  logic        Write;
  logic [31:0] MDataIn;
  logic        MemBusy;
  logic        MemDone;
  logic        MemErr;

  int          checks_total;
  int          checks_passed;
  exp_t        sb_q [$];
  logic [31:0] model_mem [int];
  logic [31:0] model_rd;

  mem_responder #(
    .DATA_W(32), .ADDR_W(9), .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .Clear(Clear), .Addr(Addr), .WrData(WrData),
    .Read(Read), .Write(Write), .MDataIn(MDataIn),
    .MemBusy(MemBusy), .MemDone(MemDone), .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Full request/handshake; expected result computed from the bench model and queued at drive time.
  task automatic do_req(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    int   waited;
    int   busy_cnt;
    logic seen;
    if (rd) begin
      e.data = (int'(a) < DEP) ? model_mem[int'(a)] : 32'h0000_0000;
      model_rd = e.data;
    end else begin
      if (int'(a) < DEP) model_mem[int'(a)] = d;
      e.data = model_rd;
    end
`ifdef MEM_BOUNDS_CHECK_EN
    e.err = (int'(a) >= DEP);
`else
    e.err = 1'b0;
`endif
    sb_q.push_back(e);
    @(negedge clk);
    Read = rd; Write = wr; Addr = a; WrData = d;
    waited = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      // scramble inputs once the request is latched
      if (waited == 1) begin
        Addr = ~a; WrData = ~d;
      end
      if (MemDone) seen = 1'b1;
      else if (MemBusy) busy_cnt++;
    end
    check_eq("done_latency", 32'(waited), 32'(LAT + 1));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(LAT));
    e = sb_q.pop_front();
    check_eq("mdata", MDataIn, e.data);
    check_eq("memerr", {31'd0, MemErr}, {31'd0, e.err});
    @(negedge clk);
    check_eq("done_hold", {31'd0, MemDone}, 32'd1);
    Read = 1'b0; Write = 1'b0;
    @(negedge clk);
    check_eq("done_drop", {31'd0, MemDone}, 32'd0);
    check_eq("err_drop", {31'd0, MemErr}, 32'd0);
    check_eq("mdata_hold", MDataIn, e.data);
  endtask

  initial begin
    checks_total = 0; checks_passed = 0; model_rd = 32'h0000_0000;
    Clear = 1'b1; Read = 1'b1; Write = 1'b0; Addr = 9'h000; WrData = 32'h0000_0000;
    // reset wins over a pending read
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_mdata", MDataIn, 32'h0000_0000);
      check_eq("rst_busy", {31'd0, MemBusy}, 32'd0);
      check_eq("rst_done", {31'd0, MemDone}, 32'd0);
    end
    Clear = 1'b0; Read = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", {31'd0, MemBusy}, 32'd0);

    do_req(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 9'h010, 32'h0000_0000);
    do_req(1'b1, 1'b1, 9'h010, 32'h0000_0000);
    do_req(1'b0, 1'b1, 9'h030, 32'h0BAD_F00D);
    do_req(1'b1, 1'b0, 9'h030, 32'h0000_0000);
    do_req(1'b1, 1'b0, 9'h010, 32'h0000_0000);

    // Clear during WAIT aborts the write and zeroes MDataIn
    do_req(1'b0, 1'b1, 9'h020, 32'hCAFE_F00D);
    @(negedge clk);
    Write = 1'b1; Addr = 9'h020; WrData = 32'h1234_5678;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, MemBusy}, 32'd1);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0; Write = 1'b0;
    model_rd = 32'h0000_0000;
    check_eq("abort_mdata", MDataIn, 32'h0000_0000);
    check_eq("abort_busy0", {31'd0, MemBusy}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_nodone", {31'd0, MemDone}, 32'd0);
    end
    do_req(1'b1, 1'b0, 9'h020, 32'h0000_0000);

    // bounds: last valid word, out-of-range read, dropped out-of-range write
    do_req(1'b0, 1'b1, 9'h0FF, 32'h55AA_55AA);
    do_req(1'b1, 1'b0, 9'h0FF, 32'h0000_0000);
    do_req(1'b1, 1'b0, 9'h1FF, 32'h0000_0000);
    do_req(1'b0, 1'b1, 9'h110, 32'hFFFF_FFFF);
    do_req(1'b1, 1'b0, 9'h010, 32'h0000_0000);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      do_req(1'b0, 1'b1, 9'(9'h040 + i), rv);
      do_req(1'b1, 1'b0, 9'(9'h040 + i), 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
